// File: rtl/blk_name_csr_pkg.sv
// Shared constants for the per-block CSR responders.
package blk_name_csr_pkg;

  // Value a responder returns on a read that hits no mapped register.
  localparam logic [31:0] ADDR_DECODE_ERROR = 32'hDEAD_BEEF;

endpackage

// File: rtl/np_csr_init_pkg.sv
// Types shared by the np CSR initiator and its timeout counter.
package np_csr_init_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpRmw   = 2'd2,
    OpRsvd  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ErrOk      = 2'd0,
    ErrTimeout = 2'd1,
    ErrDecode  = 2'd2
  } err_e;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StGap    = 2'd2;
  localparam state_t StResp   = 2'd3;

endpackage

// File: rtl/np_csr_timeout.sv
// Load/enable down-counter bounding one np bus access.
module np_csr_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Reload on access entry, count down each ack-less cycle, saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final allowed cycle of the access.
  assign expire_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/np_csr_initiator.sv
// Bus-master side of the np CSR interface: runs READ/WRITE/RMW commands as
// single-beat np accesses with an ack timeout and returns data plus error code.
module np_csr_initiator
  import np_csr_init_pkg::*;
  import blk_name_csr_pkg::*;
#(
  parameter int unsigned NP_AWIDTH      = 16,
  parameter int unsigned NP_DWIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 np_clk,
  input  logic                 np_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [NP_AWIDTH-1:0] cmd_addr,
  input  logic [NP_DWIDTH-1:0] cmd_wdata,
  input  logic [NP_DWIDTH-1:0] cmd_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NP_DWIDTH-1:0] rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic                 np_cs,
  output logic                 np_wr,
  output logic [NP_AWIDTH-1:0] np_addr,
  output logic [NP_DWIDTH-1:0] np_wdata,
  input  logic [NP_DWIDTH-1:0] np_rdata,
  input  logic                 np_ack
);

  localparam logic [NP_DWIDTH-1:0] DecodeErr = NP_DWIDTH'(ADDR_DECODE_ERROR);

  state_t                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [NP_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [NP_DWIDTH-1:0]   mask_q, mask_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [NP_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  err_e                   rsp_err_q, rsp_err_d;
  logic                   np_cs_q, np_cs_d;
  logic                   np_wr_q, np_wr_d;
  logic [NP_AWIDTH-1:0]   np_addr_q, np_addr_d;
  logic [NP_DWIDTH-1:0]   np_wdata_q, np_wdata_d;

  logic                   tmr_load, tmr_en, tmr_expire;
  logic [NP_DWIDTH-1:0]   merged;

  assign merged = (np_rdata & ~mask_q) | (wdata_q & mask_q);

  np_csr_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (np_clk),
    .rst_ni  (np_rst_n),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  // Next-state logic for the FSM, captured command and registered outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    np_cs_d     = np_cs_q;
    np_wr_d     = np_wr_q;
    np_addr_d   = np_addr_q;
    np_wdata_d  = np_wdata_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          state_d     = StAccess;
          op_d        = op_e'(cmd_op);
          wdata_d     = cmd_wdata;
          mask_d      = cmd_mask;
          np_cs_d     = 1'b1;
          np_wr_d     = (op_e'(cmd_op) == OpWrite);
          np_addr_d   = cmd_addr;
          np_wdata_d  = cmd_wdata;
          tmr_load    = 1'b1;
        end
      end

      StAccess: begin
        // np_cs is always high here, so any ack completes the access.
        if (np_ack) begin
          np_cs_d = 1'b0;
          case (op_q)
            OpWrite: begin
              state_d     = StResp;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = '0;
              rsp_err_d   = ErrOk;
            end
            OpRmw: begin
              if (np_wr_q) begin
                // Write phase done: report the merged value written.
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = np_wdata_q;
                rsp_err_d   = ErrOk;
              end else if (np_rdata == DecodeErr) begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = np_rdata;
                rsp_err_d   = ErrDecode;
              end else begin
                state_d    = StGap;
                np_wdata_d = merged;
              end
            end
            default: begin
              // READ and the reserved opcode.
              state_d     = StResp;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = np_rdata;
              rsp_err_d   = (np_rdata == DecodeErr) ? ErrDecode : ErrOk;
            end
          endcase
        end else if (tmr_expire) begin
          np_cs_d     = 1'b0;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = ErrTimeout;
        end else begin
          tmr_en = 1'b1;
        end
      end

      StGap: begin
        // Single idle bus cycle between RMW read and write phases.
        state_d  = StAccess;
        np_cs_d  = 1'b1;
        np_wr_d  = 1'b1;
        tmr_load = 1'b1;
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops np_cs and rsp_valid immediately.
  always_ff @(posedge np_clk or negedge np_rst_n) begin
    if (!np_rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      wdata_q     <= '0;
      mask_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ErrOk;
      np_cs_q     <= 1'b0;
      np_wr_q     <= 1'b0;
      np_addr_q   <= '0;
      np_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      np_cs_q     <= np_cs_d;
      np_wr_q     <= np_wr_d;
      np_addr_q   <= np_addr_d;
      np_wdata_q  <= np_wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign np_cs     = np_cs_q;
  assign np_wr     = np_wr_q;
  assign np_addr   = np_addr_q;
  assign np_wdata  = np_wdata_q;

endmodule

// File: tb/tb_np_csr_initiator.sv
// Self-checking bench for np_csr_initiator with a response scoreboard.
module tb_np_csr_initiator;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RMW   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] E_OK     = 2'd0;
  localparam logic [1:0] E_TMO    = 2'd1;
  localparam logic [1:0] E_DEC    = 2'd2;
  localparam logic [31:0] BAD     = 32'hDEAD_BEEF;

  logic        np_clk = 1'b0;
  logic        np_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        np_cs;
  logic        np_wr;
  logic [15:0] np_addr;
  logic [31:0] np_wdata;
  logic [31:0] np_rdata;
  logic        np_ack;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  np_csr_initiator #(
    .NP_AWIDTH     (16),
    .NP_DWIDTH     (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .np_clk   (np_clk),
    .np_rst_n (np_rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_mask (cmd_mask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .np_cs    (np_cs),
    .np_wr    (np_wr),
    .np_addr  (np_addr),
    .np_wdata (np_wdata),
    .np_rdata (np_rdata),
    .np_ack   (np_ack)
  );

  always #5 np_clk = ~np_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [1:0] op, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [31:0] mk);
    @(negedge np_clk);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_mask  = mk;
    @(posedge np_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    cmd_mask  = $urandom;
  endtask

  // Follow one np access; ack during its (ack_at+1)-th cs cycle (-1 = never).
  task automatic bus_phase(input logic xwr, input logic [15:0] xaddr, input logic [31:0] xwd,
                           input bit chk_wd, input int ack_at, input logic [31:0] rd,
                           input int xcyc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge np_clk);
      np_ack = 1'b0;
      if (np_cs) begin
        check_eq("cs_wr", np_wr, xwr);
        check_eq("cs_addr", np_addr, xaddr);
        if (chk_wd) check_eq("cs_wdata", np_wdata, xwd);
        if (n == ack_at) begin
          np_ack   = 1'b1;
          np_rdata = rd;
        end
        n++;
      end else begin
        done = 1'b1;
      end
    end
    check_eq("cs_cycles", n, xcyc);
  endtask

  // Called at the negedge where the response must first be visible.
  task automatic rsp_phase(input int hold);
    exp_t e;
    check_eq("rsp_valid_latency", rsp_valid, 1);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got 0 entries, expected 1");
    end else begin
      e = sb[0];
      for (int i = 0; i < hold; i++) begin
        check_eq("hold_valid", rsp_valid, 1);
        check_eq("hold_rdata", rsp_rdata, e.rdata);
        check_eq("hold_err", rsp_err, e.err);
        check_eq("hold_cmd_ready", cmd_ready, 0);
        check_eq("hold_cs", np_cs, 0);
        @(negedge np_clk);
      end
      e = sb.pop_front();
      rsp_ready = 1'b1;
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_rdata", rsp_rdata, e.rdata);
      check_eq("rsp_err", rsp_err, e.err);
      @(posedge np_clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge np_clk);
      check_eq("rsp_drop", rsp_valid, 0);
      check_eq("cmd_ready_after_rsp", cmd_ready, 1);
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [31:0] mk, input logic [31:0] rd0, input int ack0,
                     input int cyc0, input logic [31:0] rd1, input int ack1, input int cyc1,
                     input bit two, input logic [31:0] xr, input logic [1:0] xe,
                     input int hold);
    exp_t e;
    logic [31:0] merged;
    merged = (rd0 & ~mk) | (wd & mk);
    issue(op, addr, wd, mk);
    e.rdata = xr;
    e.err   = xe;
    sb.push_back(e);
    bus_phase(op == OP_WRITE, addr, wd, op == OP_WRITE, ack0, rd0, cyc0);
    if (two) bus_phase(1'b1, addr, merged, 1'b1, ack1, rd1, cyc1);
    rsp_phase(hold);
  endtask

  initial begin
    logic [31:0] r_rd, r_wd, r_mk;
    np_rst_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_mask  = '0;
    rsp_ready = 1'b0;
    np_rdata  = '0;
    np_ack    = 1'b0;

    #12;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_cs", np_cs, 0);
    check_eq("rst_wr", np_wr, 0);
    check_eq("rst_addr", np_addr, 0);
    check_eq("rst_wdata", np_wdata, 0);
    @(negedge np_clk);
    np_rst_n = 1'b1;

    // Stray ack while idle must be ignored.
    @(negedge np_clk);
    np_ack   = 1'b1;
    np_rdata = BAD;
    @(negedge np_clk);
    np_ack = 1'b0;
    check_eq("stray_ack_rsp", rsp_valid, 0);
    check_eq("stray_ack_cs", np_cs, 0);

    // op, addr, wdata, mask, rd0, ack0, cyc0, rd1, ack1, cyc1, two, exp rdata, exp err, hold
    txn(OP_READ, 16'h0020, 32'h0, 32'h0, 32'h0000_A55A, 0, 1, 32'h0, 0, 0, 0,
        32'h0000_A55A, E_OK, 0);
    txn(OP_WRITE, 16'h0021, 32'h1234_5678, 32'h0, 32'h0, 3, 4, 32'h0, 0, 0, 0,
        32'h0, E_OK, 0);
    txn(OP_RMW, 16'h0022, 32'h0000_00AB, 32'h0000_00FF, 32'h0000_FF00, 0, 1, 32'h0, 0, 1, 1,
        32'h0000_FFAB, E_OK, 0);
    txn(OP_READ, 16'h07F0, 32'h0, 32'h0, BAD, 0, 1, 32'h0, 0, 0, 0, BAD, E_DEC, 0);
    txn(OP_RMW, 16'h07F1, 32'h1, 32'h1, BAD, 0, 1, 32'h0, 0, 0, 0, BAD, E_DEC, 3);
    txn(OP_READ, 16'h0030, 32'h0, 32'h0, 32'h0, -1, 4, 32'h0, 0, 0, 0, 32'h0, E_TMO, 0);
    txn(OP_READ, 16'h0031, 32'h0, 32'h0, 32'h0000_0055, 3, 4, 32'h0, 0, 0, 0,
        32'h0000_0055, E_OK, 0);
    txn(OP_READ, 16'h0032, 32'h0, 32'h0, 32'h0BAD_F00D, 1, 2, 32'h0, 0, 0, 0,
        32'h0BAD_F00D, E_OK, 10);
    txn(OP_RSVD, 16'h0033, 32'h9, 32'h0, 32'h0000_0077, 0, 1, 32'h0, 0, 0, 0,
        32'h0000_0077, E_OK, 0);
    txn(OP_RMW, 16'h0034, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, -1, 4, 32'h0, 0, 0, 0,
        32'h0, E_TMO, 2);

    for (int i = 0; i < 3; i++) begin
      r_rd = $urandom;
      r_wd = $urandom;
      r_mk = $urandom;
      if (r_rd == BAD) r_rd = 32'h0;
      txn(OP_RMW, 16'(16'h0100 + i), r_wd, r_mk, r_rd, i, i + 1, 32'h0, 2 - i, 3 - i, 1,
          (r_rd & ~r_mk) | (r_wd & r_mk), E_OK, i);
    end

    // Reset in the middle of an access: bus strobe drops at once, no response.
    issue(OP_READ, 16'h0040, 32'h0, 32'h0);
    @(negedge np_clk);
    check_eq("pre_rst_cs1", np_cs, 1);
    @(negedge np_clk);
    check_eq("pre_rst_cs2", np_cs, 1);
    #1 np_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs", np_cs, 0);
    check_eq("mid_rst_rsp", rsp_valid, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge np_clk);
    np_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge np_clk);
      check_eq("post_rst_rsp", rsp_valid, 0);
      check_eq("post_rst_cs", np_cs, 0);
    end

    txn(OP_READ, 16'h0041, 32'h0, 32'h0, 32'hCAFE_0001, 1, 2, 32'h0, 0, 0, 0,
        32'hCAFE_0001, E_OK, 1);

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/np_csr_initiator.md
# np_csr_initiator

Bus-master side of the np CSR interface. It accepts register commands (read, write, read-modify-write) on a valid/ready port and runs them as single-beat np bus accesses to CSR blocks. Each access is bounded by an ack timeout, and the block returns read data plus an error code on a response port. It sits between the np0 control sequencer / debug port and the per-block `*_csr` responders.

## Interface
Parameters:
- NP_AWIDTH, 16, CPU address-bus width
- NP_DWIDTH, 32, CPU data-bus width
- TIMEOUT_CYCLES, 255, maximum number of cycles np_cs is held without np_ack; must be ≥1

Ports:
- np_clk  in  1  sole clock
- np_rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0 = READ, 1 = WRITE, 2 = RMW, 3 = reserved (treated as READ)
- cmd_addr  in  NP_AWIDTH  register address
- cmd_wdata  in  NP_DWIDTH  write data
- cmd_mask  in  NP_DWIDTH  RMW bit mask (1 = take cmd_wdata bit)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  NP_DWIDTH  read data / written value
- rsp_err  out  2  0 = OK, 1 = TIMEOUT, 2 = DECODE
- np_cs  out  1  bus access strobe
- np_wr  out  1  1 = write, 0 = read
- np_addr  out  NP_AWIDTH  bus address
- np_wdata  out  NP_DWIDTH  bus write data
- np_rdata  in  NP_DWIDTH  bus read data, valid with np_ack
- np_ack  in  1  single-cycle access completion

## Operation
- FSM states:
  - IDLE → ACCESS on cmd accept.
  - ACCESS → GAP on RMW read-phase success.
  - GAP → ACCESS for the RMW write phase.
  - ACCESS → RESP on completion or error.
  - RESP → IDLE on rsp handshake.
- cmd_ready = 1 only in IDLE; it is 0 while np_rst_n is low. Command fields are registered on accept and held until RESP exits.
- ACCESS drives np_cs=1 with np_addr/np_wr/np_wdata stable for the whole access. Completion is the first cycle np_ack=1 while np_cs=1. np_ack with np_cs=0 is ignored.
- READ:
  - rsp_rdata = captured np_rdata.
  - If captured data == ADDR_DECODE_ERROR (32'hDEADBEEF), rsp_err=DECODE; otherwise OK.
- WRITE: rsp_rdata = 0, rsp_err=OK.
- RMW:
  - Read phase first.
  - Merged value = (rdata & ~mask) | (wdata & mask), computed at NP_DWIDTH with no extension.
  - One GAP cycle with np_cs=0, then the write phase with the merged value.
  - rsp_rdata = merged value.
  - If the read phase returns DECODE or TIMEOUT, the write phase is skipped and that error is reported; rsp_rdata = value read (0 on timeout).
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with np_ack=0.
  - When TIMEOUT_CYCLES ack-less cycles have elapsed, np_cs drops and rsp_err=TIMEOUT, rsp_rdata=0.
  - np_ack in the final allowed cycle counts as success: ack wins over timeout.
- rsp_valid holds, with rsp_rdata/rsp_err stable, until rsp_ready.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, np_cs=0, np_wr=0, np_addr=0, np_wdata=0; FSM in IDLE.
- Reset mid-operation: np_cs and rsp_valid drop asynchronously. The in-flight command is lost and no response is issued.
- Accept at cycle 0 → np_cs=1 at cycle 1. With ack at cycle 1 → rsp_valid=1 at cycle 2. Minimum READ/WRITE latency is 2 cycles.
- np_cs deasserts the cycle after ack. Back-to-back accesses therefore always have ≥1 cycle of np_cs=0.
- RMW with zero-wait acks:
  - Read cs at cycle 1.
  - GAP at cycle 2.
  - Write cs at cycle 3.
  - rsp_valid at cycle 4.
- rsp_valid=1 and rsp_ready=1 at cycle N → cmd_ready=1 at cycle N+1. Next np_cs no earlier than N+2.
- All outputs are registered; there is no combinational path from np_* inputs to np_* outputs.

## Structure
- Package np_csr_init_pkg:
  - op enum (READ/WRITE/RMW)
  - err enum (OK/TIMEOUT/DECODE)
  - FSM state typedef
- ADDR_DECODE_ERROR is imported from blk_name_csr_pkg, not redefined.
- One sub-module, np_csr_timeout: load/enable down-counter of width $clog2(TIMEOUT_CYCLES+1) with an expire flag. Everything else stays in np_csr_initiator.

## Test plan
- READ 0x0020, responder acks at cycle 1 with 0x0000_A55A → rsp_valid at cycle 2, rdata 0x0000_A55A, err OK.
- WRITE 0x0021 data 0x1234_5678, ack after 3 wait cycles → np_wr=1 with np_addr/np_wdata stable for 4 cycles; rsp rdata 0, err OK.
- RMW 0x0022, read returns 0x0000_FF00, wdata 0x0000_00AB, mask 0x0000_00FF → one GAP cycle, write data 0x0000_FFAB, rsp rdata 0x0000_FFAB, err OK.
- READ of an unmapped address returning 0xDEADBEEF → err DECODE, rdata 0xDEADBEEF. Same case as RMW → no write-phase np_cs.
- TIMEOUT_CYCLES=4, no ack:
  - np_cs high exactly 4 cycles, then err TIMEOUT, rdata 0.
  - Repeat with ack on cycle 4 → err OK.
- rsp_ready held low 10 cycles → rsp stable and cmd_ready=0 throughout. Separately, assert np_rst_n low mid-ACCESS → np_cs=0 immediately, no response after reset.
